hyperbus_wb_bridge: RTL and testbench

Wishbone B4 classic slave that turns 32-bit CPU bus cycles into single-word requests on the user-clock side of the Hyperbus dual-clock FIFO interface. It sits directly upstream of the FIFO block and drives its rrq/wrq/adr_i/tx_dat_i inputs. It consumes that block's tx_ready/rx_dat_o/rx_valid outputs. The FIFO block gives no command-full visibility, so the bridge keeps at most one request outstanding. Reads, writes and faults complete with ack or err plus a timeout.

---
 rtl/hyperbus_wb_bridge.sv | 151 +++++++++++++++
 tb/tb_hyperbus_wb_bridge.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone B4 classic slave issuing single-word read/write requests to the
// Hyperbus FIFO block user side, with one request outstanding and a timeout.
module hyperbus_wb_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ADDR_SHIFT = 1,
  parameter int GUARD      = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    rrq,
  output logic                    wrq,
  output logic [ADDR_WIDTH-1:0]   adr_o,
  output logic [DATA_WIDTH-1:0]   tx_dat_o,
  input  logic                    tx_ready,
  input  logic [DATA_WIDTH-1:0]   rx_dat_i,
  input  logic                    rx_valid,
  output logic                    busy_o,
  output logic [2:0]              fsm_state
);

  // Wishbone handshake: a cycle is accepted only in IDLE when cyc&stb are high;
  // it ends with exactly one ack or err pulse, and the master must drop stb then.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    WR_GUARD = 3'd2,
    WR_DRAIN = 3'd3,
    RESP     = 3'd4,
    ABORT    = 3'd5
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GUARD + 2);

  state_t          state;
  logic [CW-1:0]   tmo;
  logic [GW-1:0]   gcnt;
  logic            is_wr;
  logic            counting;
  logic            tmo_zero;
  logic            abort_done;

  always_comb begin
    counting   = 1'b0;
    abort_done = 1'b0;
    counting   = (state == RD_WAIT) || (state == WR_GUARD) ||
                 (state == WR_DRAIN) || (state == ABORT);
    abort_done = is_wr ? ((gcnt == '0) && tx_ready) : rx_valid;
  end

  assign tmo_zero  = (tmo == '0);
  assign busy_o    = (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tmo      <= '0;
      gcnt     <= '0;
      is_wr    <= 1'b0;
      rrq      <= 1'b0;
      wrq      <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      adr_o    <= '0;
      tx_dat_o <= '0;
    end else begin
      rrq      <= 1'b0;
      wrq      <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      if (counting && !tmo_zero) tmo <= tmo - CW'(1);
      if (((state == WR_GUARD) || (state == ABORT)) && (gcnt != '0)) gcnt <= gcnt - GW'(1);
      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            if (wb_we_i && !(&wb_sel_i)) begin
              wb_err_o <= 1'b1;
              state    <= RESP;
            end else begin
              adr_o <= wb_adr_i >> ADDR_SHIFT;
              tmo   <= CW'(TIMEOUT);
              is_wr <= wb_we_i;
              if (wb_we_i) begin
                wrq      <= 1'b1;
                tx_dat_o <= wb_dat_i;
                gcnt     <= GW'(GUARD);
                state    <= (GUARD == 0) ? WR_DRAIN : WR_GUARD;
              end else begin
                rrq   <= 1'b1;
                state <= RD_WAIT;
              end
            end
          end
        end
        RD_WAIT: begin
          // An abandoned cycle whose reply lands on the same edge needs no ABORT wait.
          if (!wb_cyc_i) begin
            state <= (rx_valid || tmo_zero) ? IDLE : ABORT;
          end else if (rx_valid) begin
            wb_dat_o <= rx_dat_i;
            wb_ack_o <= 1'b1;
            state    <= RESP;
          end else if (tmo_zero) begin
            wb_err_o <= 1'b1;
            state    <= RESP;
          end
        end
        WR_GUARD: begin
          if (!wb_cyc_i) begin
            state <= tmo_zero ? IDLE : ABORT;
          end else if (tmo_zero) begin
            wb_err_o <= 1'b1;
            state    <= RESP;
          end else if (gcnt <= GW'(1)) begin
            state <= WR_DRAIN;
          end
        end
        WR_DRAIN: begin
          if (!wb_cyc_i) begin
            state <= (tx_ready || tmo_zero) ? IDLE : ABORT;
          end else if (tx_ready) begin
            wb_ack_o <= 1'b1;
            state    <= RESP;
          end else if (tmo_zero) begin
            wb_err_o <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: state <= IDLE;
        ABORT: begin
          if (abort_done || tmo_zero) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// Bench for hyperbus_wb_bridge: directed scenarios plus randomized cycles
// checked against a timing model of completion cycle, response kind and data.
module tb_hyperbus_wb_bridge;
  localparam int G  = 8;
  localparam int T  = 64;
  localparam int TT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_cyc, a_stb, b_cyc, b_stb, we;
  logic [31:0] adr, wdat, rx_dat;
  logic [3:0]  sel;
  logic        tx_ready, rx_valid;

  logic [31:0] a_dat, a_adr, a_tx, b_dat, b_adr, b_tx;
  logic        a_ack, a_err, a_rrq, a_wrq, a_busy;
  logic        b_ack, b_err, b_rrq, b_wrq, b_busy;
  logic [2:0]  a_state, b_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;

  always #5 clk = ~clk;

  hyperbus_wb_bridge #(.GUARD(G), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .wb_cyc_i(a_cyc), .wb_stb_i(a_stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(a_dat),
    .wb_ack_o(a_ack), .wb_err_o(a_err), .rrq(a_rrq), .wrq(a_wrq), .adr_o(a_adr),
    .tx_dat_o(a_tx), .tx_ready(tx_ready), .rx_dat_i(rx_dat), .rx_valid(rx_valid),
    .busy_o(a_busy), .fsm_state(a_state)
  );

  hyperbus_wb_bridge #(.GUARD(G), .TIMEOUT(TT)) dut_t (
    .clk(clk), .rst_n(rst_n), .wb_cyc_i(b_cyc), .wb_stb_i(b_stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(b_dat),
    .wb_ack_o(b_ack), .wb_err_o(b_err), .rrq(b_rrq), .wrq(b_wrq), .adr_o(b_adr),
    .tx_dat_o(b_tx), .tx_ready(tx_ready), .rx_dat_i(rx_dat), .rx_valid(rx_valid),
    .busy_o(b_busy), .fsm_state(b_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_bus(input bit use_t, input logic v);
    if (use_t) begin b_cyc = v; b_stb = v; end
    else begin a_cyc = v; a_stb = v; end
  endtask

  task automatic sample(input bit use_t, output logic ack, output logic err,
                        output logic rq, output logic wq, output logic bsy,
                        output logic [31:0] dat, output logic [31:0] ao, output logic [31:0] txo);
    if (use_t) begin
      ack = b_ack; err = b_err; rq = b_rrq; wq = b_wrq; bsy = b_busy; dat = b_dat; ao = b_adr; txo = b_tx;
    end else begin
      ack = a_ack; err = a_err; rq = a_rrq; wq = a_wrq; bsy = a_busy; dat = a_dat; ao = a_adr; txo = a_tx;
    end
  endtask

  // Cycle numbers count edges from the accepting edge (0). d/r = edge at which
  // rx_valid / tx_ready is first seen (0 = never). Returns the response edge.
  function automatic void predict(input bit w, input logic [3:0] s, input int d, input int r,
                                  input int tmo, output int k_o, output bit err_o);
    int k;
    if (w && s != 4'hF) begin
      k_o = 0; err_o = 1'b1;
    end else if (!w) begin
      if (d >= 1 && d <= tmo + 1) begin k_o = d; err_o = 1'b0; end
      else begin k_o = tmo + 1; err_o = 1'b1; end
    end else begin
      k = (r == 0) ? -1 : ((r > G + 1) ? r : G + 1);
      if (k >= 1 && k <= tmo + 1) begin k_o = k; err_o = 1'b0; end
      else begin k_o = tmo + 1; err_o = 1'b1; end
    end
  endfunction

  task automatic do_txn(input bit use_t, input bit w, input logic [31:0] a, input logic [31:0] dt,
                        input logic [3:0] s, input int d, input int r, input logic [31:0] rdat);
    int tmo, exp_k, got_k, reqs;
    bit exp_err, got_err, seen, bad;
    logic ack, err, rq, wq, bsy;
    logic [31:0] dat, ao, txo, last;
    tmo = use_t ? TT : T;
    bad = w && (s != 4'hF);
    predict(w, s, d, r, tmo, exp_k, exp_err);
    exp_q.delete();
    if (!w && !exp_err) exp_q.push_back(rdat);
    @(negedge clk);
    we = w; adr = a; wdat = dt; sel = s; rx_dat = rdat; rx_valid = 1'b0; tx_ready = 1'b0;
    set_bus(use_t, 1'b1);
    seen = 0; got_k = -1; got_err = 0; reqs = 0;
    for (int k = 0; k <= 200 && !seen; k++) begin
      @(posedge clk); @(negedge clk);
      sample(use_t, ack, err, rq, wq, bsy, dat, ao, txo);
      reqs += int'(rq) + int'(wq);
      if (k == 0 && !bad) begin
        check("req_kind", {rq, wq}, w ? 2'b01 : 2'b10);
        check("adr_o", ao, a >> 1);
        if (w) check("tx_dat_o", txo, dt);
      end
      if (ack || err) begin
        seen = 1; got_k = k; got_err = err;
        check("ack_err_excl", ack && err, 0);
        if (ack && !w) begin
          check("rd_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("rd_data", dat, exp_q.pop_front());
        end
        set_bus(use_t, 1'b0); rx_valid = 1'b0; tx_ready = 1'b0;
      end else begin
        rx_valid = (d >= 1 && k + 1 == d);
        tx_ready = (r >= 1 && k + 1 >= r);
      end
    end
    if (!seen) begin set_bus(use_t, 1'b0); rx_valid = 1'b0; tx_ready = 1'b0; end
    check("done_seen", seen, 1);
    check("done_cycle", got_k, exp_k);
    check("done_is_err", got_err, exp_err);
    check("req_count", reqs, bad ? 0 : 1);
    if (!w && !exp_err) begin
      if (use_t) last_b = rdat; else last_a = rdat;
    end
    last = use_t ? last_b : last_a;
    @(posedge clk); @(negedge clk);
    sample(use_t, ack, err, rq, wq, bsy, dat, ao, txo);
    check("idle_busy", bsy, 0);
    check("idle_no_resp", {ack, err, rq, wq}, 0);
    check("dat_hold", dat, last);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; a_cyc = 0; a_stb = 0; b_cyc = 0; b_stb = 0; we = 0;
    adr = '0; wdat = '0; sel = '0; tx_ready = 0; rx_valid = 0; rx_dat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {a_ack, a_err, a_rrq, a_wrq, a_busy}, 0);
    check("rst_data", {a_dat, a_adr, a_tx}, 0);
    rst_n = 1'b1;

    // Directed scenarios
    do_txn(0, 0, 32'h0000_0100, 32'h0, 4'hF, 5, 0, 32'hDEAD_BEEF);
    do_txn(0, 1, 32'h0000_0040, 32'h1234_5678, 4'hF, 0, 21, 32'h0);
    do_txn(0, 1, 32'h0000_0044, 32'h1111_2222, 4'h3, 0, 1, 32'h0);
    do_txn(0, 1, 32'h0000_0048, 32'h3333_4444, 4'hF, 0, 1, 32'h0);
    do_txn(1, 0, 32'h0000_0300, 32'h0, 4'hF, 0, 0, 32'h0);

    // Late reply after timeout must be ignored
    rx_dat = 32'hAAAA_5555; rx_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) begin
      check("late_no_ack", {b_ack, b_err}, 0);
      check("late_dat", b_dat, last_b);
      @(posedge clk); @(negedge clk);
    end
    check("late_main_dat", a_dat, last_a);

    // Abort: drop cyc two cycles after rrq
    we = 0; adr = 32'h0000_0200; sel = 4'hF; set_bus(0, 1'b1);
    @(posedge clk); @(negedge clk);
    check("abort_rrq", a_rrq, 1);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    set_bus(0, 1'b0);
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      check("abort_busy", a_busy, 1);
      check("abort_no_resp", {a_ack, a_err}, 0);
    end
    rx_dat = 32'h5555_1234; rx_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    rx_valid = 1'b0;
    check("abort_idle", a_busy, 0);
    check("abort_no_resp2", {a_ack, a_err}, 0);
    check("abort_dat", a_dat, last_a);
    do_txn(0, 0, 32'h0000_0204, 32'h0, 4'hF, 3, 0, 32'h0BAD_F00D);

    // Reset while draining a write
    @(negedge clk);
    we = 1; adr = 32'h0000_0080; wdat = 32'hCAFE_F00D; sel = 4'hF; tx_ready = 0; set_bus(0, 1'b1);
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("drain_busy", a_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {a_ack, a_err, a_rrq, a_wrq, a_busy}, 0);
    check("mid_rst_data", {a_dat, a_adr, a_tx}, 0);
    set_bus(0, 1'b0);
    last_a = '0; last_b = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(0, 0, 32'h0000_0010, 32'h0, 4'hF, 2, 0, 32'h600D_0001);

    // Randomized cycles
    for (int i = 0; i < 40; i++) begin
      bit          w;
      logic [3:0]  s;
      int          d, r;
      w = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, T + 6);
      r = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, T + 6);
      do_txn(0, w, $urandom, $urandom, s, d, r, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
